pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports:
- i_clk  in  1  sole clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_id_rs1, i_id_rs2  in  5 each  ID-stage source registers
- i_id_rs1_used, i_id_rs2_used  in  1 each  source actually read
- i_ex_valid, i_ex_memread  in  1 each  EX holds a valid load
- i_ex_rd  in  5  EX destination
- i_mem_valid, i_mem_memread  in  1 each  MEM holds a valid load
- i_mem_rd  in  5  MEM destination
- i_ex_mispred  in  1  branch/jump resolved mispredicted in EX
- i_dmem_stall  in  1  data memory not ready
- o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall, o_memwb_stall  out  1 each  hold stage
- o_ifid_flush, o_idex_flush  out  1 each  bubble stage
- o_state  out  2  FSM state: RUN=0, LU2=1, LU1=2, REDIR=3
- o_cnt_stall  out  32  load-use stall cycles
- o_cnt_mispred  out  32  mispredict events

Function
REQ-002 SHALL be a Moore/Mealy hybrid: registered FSM and counters, combinational outputs from state and inputs.
REQ-003 SHALL define hit1 = i_ex_valid & i_ex_memread & i_ex_rd!=0 & ((i_id_rs1_used & rs1==ex_rd) | (i_id_rs2_used & rs2==ex_rd)).
REQ-004 SHALL define hit2 identically against i_mem_valid/i_mem_memread/i_mem_rd.
REQ-005 SHALL apply priority: i_reset > i_dmem_stall > i_ex_mispred > load-use.
REQ-006 Freeze: i_dmem_stall=1 SHALL assert all five stall outputs, no flush, hold state, count nothing.
REQ-007 RUN, i_ex_mispred=1: SHALL assert o_ifid_flush and o_idex_flush, no stalls, increment o_cnt_mispred, go REDIR.
REQ-008 REDIR: SHALL assert o_ifid_flush only (one-cycle shadow for gshare redirect fetch), go RUN next cycle; i_ex_mispred here SHALL be treated as in REQ-007 (stay REDIR, count again).
REQ-009 RUN, hit1: SHALL assert o_pc_stall, o_ifid_stall, o_idex_flush, increment o_cnt_stall, go LU2.
REQ-010 RUN, hit2 without hit1: SHALL assert same outputs as REQ-009, increment o_cnt_stall, go LU1.
REQ-011 LU2: SHALL assert stall/bubble as REQ-009, increment o_cnt_stall, go LU1 regardless of hazard inputs.
REQ-012 LU1: SHALL assert stall/bubble as REQ-009, increment o_cnt_stall, go RUN; load data then forwarded from WB.
REQ-013 i_ex_mispred in LU2/LU1 SHALL abort the stall: behave as REQ-007, go REDIR.
REQ-014 Load-use with rd=x0 SHALL never stall.
REQ-015 Counters SHALL wrap modulo 2^32 (0xFFFFFFFF+1 -> 0), no saturation.
REQ-016 o_exmem_stall and o_memwb_stall SHALL be asserted only under REQ-006.

Reset
REQ-017 i_reset=1 at a rising edge SHALL force state RUN and both counters 0, overriding every other input, including mid-stall or mid-redirect.
REQ-018 While i_reset=1, all stall and flush outputs SHALL be 0.
REQ-019 First cycle after reset release SHALL evaluate hazards from RUN.

Verification
REQ-020 Load x5 in EX, ID add uses rs1=x5 -> 3 cycles stall+bubble (RUN,LU2,LU1), o_cnt_stall=3, then RUN.
REQ-021 Load x5 in MEM only, ID uses x5 -> 2 cycles stall (RUN,LU1), o_cnt_stall=2.
REQ-022 i_ex_mispred pulse in RUN -> cycle0 ifid+idex flush, cycle1 ifid flush (REDIR), cycle2 RUN; o_cnt_mispred=1.
REQ-023 Mispred in LU2 -> stall aborted, REDIR next, o_cnt_stall unchanged that cycle; i_dmem_stall=1 for 4 cycles during LU1 -> all stalls high, state LU1 held, counters unchanged.
REQ-024 Preload o_cnt_stall to 0xFFFFFFFF via forced hazard run -> next stall cycle gives 0x00000000; i_reset asserted in LU2 -> RUN, counters 0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, mispredict flush and
// data-memory freeze, with stall-cycle and mispredict event counters.
module pipe_hazard_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_rs1_used,
    input  logic        i_id_rs2_used,
    input  logic        i_ex_valid,
    input  logic        i_ex_memread,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_mem_valid,
    input  logic        i_mem_memread,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_ex_mispred,
    input  logic        i_dmem_stall,
    output logic        o_pc_stall,
    output logic        o_ifid_stall,
    output logic        o_idex_stall,
    output logic        o_exmem_stall,
    output logic        o_memwb_stall,
    output logic        o_ifid_flush,
    output logic        o_idex_flush,
    output logic [1:0]  o_state,
    output logic [31:0] o_cnt_stall,
    output logic [31:0] o_cnt_mispred
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LU2   = 2'd1,
        LU1   = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               hit1_c;
    logic               hit2_c;
    logic               inc_stall_c;
    logic               inc_mispred_c;
    logic [CNT_W-1:0]   cnt_stall;
    logic [CNT_W-1:0]   cnt_mispred;

    // Load in EX / MEM whose destination a live ID source reads (x0 never hazards)
    assign hit1_c = i_ex_valid & i_ex_memread & (i_ex_rd != 5'd0) &
                    ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                     (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));
    assign hit2_c = i_mem_valid & i_mem_memread & (i_mem_rd != 5'd0) &
                    ((i_id_rs1_used & (i_id_rs1 == i_mem_rd)) |
                     (i_id_rs2_used & (i_id_rs2 == i_mem_rd)));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: freeze holds, mispredict redirects from anywhere, else walk the stall
    always_comb begin
        state_nxt = state;
        if (i_dmem_stall) begin
            state_nxt = state;
        end else if (i_ex_mispred) begin
            state_nxt = REDIR;
        end else begin
            case (state)
                RUN: begin
                    if (hit1_c) begin
                        state_nxt = LU2;
                    end else if (hit2_c) begin
                        state_nxt = LU1;
                    end
                end
                LU2:     state_nxt = LU1;
                LU1:     state_nxt = RUN;
                REDIR:   state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // Stall/flush controls and counter increment strobes from state and inputs
    always_comb begin
        o_pc_stall    = 1'b0;
        o_ifid_stall  = 1'b0;
        o_idex_stall  = 1'b0;
        o_exmem_stall = 1'b0;
        o_memwb_stall = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        inc_stall_c   = 1'b0;
        inc_mispred_c = 1'b0;
        if (i_reset) begin
            inc_stall_c = 1'b0;
        end else if (i_dmem_stall) begin
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_stall = 1'b1;
            o_memwb_stall = 1'b1;
        end else if (i_ex_mispred) begin
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            inc_mispred_c = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hit1_c | hit2_c) begin
                        o_pc_stall   = 1'b1;
                        o_ifid_stall = 1'b1;
                        o_idex_flush = 1'b1;
                        inc_stall_c  = 1'b1;
                    end
                end
                LU2, LU1: begin
                    o_pc_stall   = 1'b1;
                    o_ifid_stall = 1'b1;
                    o_idex_flush = 1'b1;
                    inc_stall_c  = 1'b1;
                end
                REDIR: begin
                    // Squash the wrong-path fetch still in flight behind the redirect
                    o_ifid_flush = 1'b1;
                end
                default: begin
                    o_ifid_flush = 1'b0;
                end
            endcase
        end
    end

    // Event counters, wrapping modulo 2^32
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_stall   <= '0;
            cnt_mispred <= '0;
        end else begin
            if (inc_stall_c) begin
                cnt_stall <= cnt_stall + CNT_W'(1);
            end
            if (inc_mispred_c) begin
                cnt_mispred <= cnt_mispred + CNT_W'(1);
            end
        end
    end

    assign o_state       = state;
    assign o_cnt_stall   = cnt_stall;
    assign o_cnt_mispred = cnt_mispred;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues hand-computed
// expectations per cycle, monitor pops and compares before each rising edge.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_rs1_used, id_rs2_used;
    logic        ex_valid, ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_valid, mem_memread;
    logic [4:0]  mem_rd;
    logic        ex_mispred, dmem_stall;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
    logic        ifid_flush, idex_flush;
    logic [1:0]  state;
    logic [31:0] cnt_stall, cnt_mispred;

    typedef struct packed {
        logic [7:0]  id;
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic [31:0] cs;
        logic [31:0] cm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    // {pc, ifid, idex, exmem, memwb stalls, ifid flush, idex flush}
    localparam logic [6:0] N  = 7'b0000000;
    localparam logic [6:0] LU = 7'b1100001;
    localparam logic [6:0] FZ = 7'b1111100;
    localparam logic [6:0] MS = 7'b0000011;
    localparam logic [6:0] RD = 7'b0000010;

    pipe_hazard_ctrl dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_rs1_used (id_rs1_used),
        .i_id_rs2_used (id_rs2_used),
        .i_ex_valid    (ex_valid),
        .i_ex_memread  (ex_memread),
        .i_ex_rd       (ex_rd),
        .i_mem_valid   (mem_valid),
        .i_mem_memread (mem_memread),
        .i_mem_rd      (mem_rd),
        .i_ex_mispred  (ex_mispred),
        .i_dmem_stall  (dmem_stall),
        .o_pc_stall    (pc_stall),
        .o_ifid_stall  (ifid_stall),
        .o_idex_stall  (idex_stall),
        .o_exmem_stall (exmem_stall),
        .o_memwb_stall (memwb_stall),
        .o_ifid_flush  (ifid_flush),
        .o_idex_flush  (idex_flush),
        .o_state       (state),
        .o_cnt_stall   (cnt_stall),
        .o_cnt_mispred (cnt_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and queue its expected response
    task automatic apply(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [1:0] exld, input logic [4:0] exrd,
                         input logic [1:0] memld, input logic [4:0] memrd,
                         input logic mis, input logic dm,
                         input logic [6:0] ctl, input logic [1:0] st,
                         input logic [31:0] cs, input logic [31:0] cm);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rs1_used = u1;
        id_rs2_used = u2;
        ex_valid    = exld[1];
        ex_memread  = exld[0];
        ex_rd       = exrd;
        mem_valid   = memld[1];
        mem_memread = memld[0];
        mem_rd      = memrd;
        ex_mispred  = mis;
        dmem_stall  = dm;
        step_no++;
        e.id  = 8'(step_no);
        e.ctl = ctl;
        e.st  = st;
        e.cs  = cs;
        e.cm  = cm;
        q.push_back(e);
    endtask

    // Monitor: sample just before each rising edge and check against the queue head
    initial begin
        exp_t e;
        logic [6:0] ctl;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() != 0) begin
                e = q.pop_front();
                ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                       ifid_flush, idex_flush};
                total++;
                if (ctl !== e.ctl) begin
                    bad++;
                    $display("FAIL step%0d ctl: got %b expected %b", e.id, ctl, e.ctl);
                end
                total++;
                if (state !== e.st) begin
                    bad++;
                    $display("FAIL step%0d state: got %0d expected %0d", e.id, state, e.st);
                end
                total++;
                if (cnt_stall !== e.cs) begin
                    bad++;
                    $display("FAIL step%0d cnt_stall: got %h expected %h", e.id, cnt_stall, e.cs);
                end
                total++;
                if (cnt_mispred !== e.cm) begin
                    bad++;
                    $display("FAIL step%0d cnt_mispred: got %h expected %h", e.id, cnt_mispred, e.cm);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // First reset cycle: state not yet defined, so nothing is checked
        @(negedge clk);
        reset = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_valid = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        mem_valid = 1'b0; mem_memread = 1'b0; mem_rd = 5'd0;
        ex_mispred = 1'b0; dmem_stall = 1'b0;

        // Reset held with a live hazard and freeze/mispredict quiet: all controls low
        apply(1, 5, 0, 1, 0, 2'b11, 5, 2'b00, 0, 0, 0, N,  0, 0, 0);
        // Load x5 in EX used by rs1: RUN, LU2, LU1 then RUN with three stalls counted
        apply(0, 5, 0, 1, 0, 2'b11, 5, 2'b00, 0, 0, 0, LU, 0, 0, 0);
        apply(0, 5, 0, 1, 0, 2'b00, 0, 2'b11, 5, 0, 0, LU, 1, 1, 0);
        apply(0, 5, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0, LU, 2, 2, 0);
        apply(0, 5, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0, N,  0, 3, 0);
        // x0 destination, unused sources, non-load producers: no stall
        apply(0, 0, 0, 1, 1, 2'b11, 0, 2'b11, 0, 0, 0, N,  0, 3, 0);
        apply(0, 7, 7, 0, 0, 2'b11, 7, 2'b11, 7, 0, 0, N,  0, 3, 0);
        apply(0, 7, 7, 1, 1, 2'b10, 7, 2'b10, 7, 0, 0, N,  0, 3, 0);
        // Load x5 in MEM only, used by rs2: RUN, LU1 then RUN
        apply(0, 0, 5, 0, 1, 2'b00, 0, 2'b11, 5, 0, 0, LU, 0, 3, 0);
        apply(0, 0, 5, 0, 1, 2'b00, 0, 2'b00, 0, 0, 0, LU, 2, 4, 0);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, N,  0, 5, 0);
        // Mispredict pulse in RUN
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, MS, 0, 5, 0);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, RD, 3, 5, 1);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, N,  0, 5, 1);
        // Back-to-back mispredict: second one lands in REDIR and stays there
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, MS, 0, 5, 1);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, MS, 3, 5, 2);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, RD, 3, 5, 3);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, N,  0, 5, 3);
        // Mispredict in LU2 aborts the stall; REDIR ignores a pending hazard
        apply(0, 5, 0, 1, 0, 2'b11, 5, 2'b00, 0, 0, 0, LU, 0, 5, 3);
        apply(0, 5, 0, 1, 0, 2'b11, 5, 2'b11, 5, 1, 0, MS, 1, 6, 3);
        apply(0, 5, 0, 1, 0, 2'b11, 5, 2'b00, 0, 0, 0, RD, 3, 6, 4);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, N,  0, 6, 4);
        // Freeze for four cycles in LU1 (one with mispredict too), then resume
        apply(0, 0, 5, 0, 1, 2'b00, 0, 2'b11, 5, 0, 0, LU, 0, 6, 4);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1, FZ, 2, 7, 4);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 1, FZ, 2, 7, 4);
        apply(0, 5, 0, 1, 0, 2'b11, 5, 2'b00, 0, 0, 1, FZ, 2, 7, 4);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1, FZ, 2, 7, 4);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, LU, 2, 7, 4);
        // Freeze in RUN beats a load-use hazard
        apply(0, 5, 0, 1, 0, 2'b11, 5, 2'b00, 0, 0, 1, FZ, 0, 8, 4);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, N,  0, 8, 4);

        // Preload the stall counter to all-ones to exercise wrap
        @(posedge clk);
        #1;
        force dut.cnt_stall = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_stall;
        apply(0, 5, 0, 1, 0, 2'b11, 5, 2'b00, 0, 0, 0, LU, 0, 32'hFFFF_FFFF, 4);
        // Reset in LU2 returns to RUN with cleared counters
        apply(1, 5, 0, 1, 0, 2'b11, 5, 2'b00, 0, 0, 0, N,  1, 0, 4);
        apply(0, 5, 0, 1, 0, 2'b11, 5, 2'b00, 0, 0, 0, LU, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, LU, 1, 1, 0);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0, MS, 2, 2, 0);
        // Reset in REDIR with mispredict and freeze asserted
        apply(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 1, N,  3, 2, 1);
        apply(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, N,  0, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
